// File: rtl/polyphase_pkg.sv
// Shared types and width helpers for the polyphase coefficient loader family.
package polyphase_pkg;

  localparam int unsigned DEF_NUMBER_TAPS       = 32;
  localparam int unsigned DEF_RATE_CHANGE       = 8;
  localparam int unsigned DEF_COEFFICIENT_WIDTH = 16;
  localparam int unsigned DEF_C_AXI_DATA_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    RST,
    WRITE,
    DONE
  } loader_state_e;

  // SUB_LENGTH: sub-taps per polyphase branch
  function automatic int unsigned sub_length(input int unsigned taps, input int unsigned rate);
    return taps / rate;
  endfunction

  // TAP_CNT_W: counter able to hold 0..n inclusive
  function automatic int unsigned tap_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // PHASE_W and friends: index into 0..n-1, never narrower than one bit
  function automatic int unsigned index_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/polyphase_coeff_loader_if.sv
// Coefficient stream in and coefficient write channel out of the loader.
interface polyphase_coeff_loader_if #(
  parameter int unsigned COEFFICIENT_WIDTH = 16,
  parameter int unsigned C_AXI_DATA_WIDTH  = 32
);

  logic [COEFFICIENT_WIDTH-1:0]  s_coeff_tdata;
  logic                          s_coeff_tvalid;
  logic                          s_coeff_tready;
  logic                          s_coeff_tlast;

  logic                          m_coeffs_wvalid;
  logic                          m_coeffs_wready;
  logic [C_AXI_DATA_WIDTH-1:0]   m_coeffs_wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] m_coeffs_wstrb;

  // loader side
  modport slave (
    input  s_coeff_tdata, s_coeff_tvalid, s_coeff_tlast, m_coeffs_wready,
    output s_coeff_tready, m_coeffs_wvalid, m_coeffs_wdata, m_coeffs_wstrb
  );

  // coefficient source / filter side
  modport master (
    output s_coeff_tdata, s_coeff_tvalid, s_coeff_tlast, m_coeffs_wready,
    input  s_coeff_tready, m_coeffs_wvalid, m_coeffs_wdata, m_coeffs_wstrb
  );

endinterface

// File: rtl/polyphase_coeff_order.sv
// Maps (phase, sub-tap) write counters to a prototype coefficient index.
module polyphase_coeff_order
  import polyphase_pkg::*;
#(
  parameter int unsigned NUMBER_TAPS      = 32,
  parameter int unsigned RATE_CHANGE      = 8,
  parameter int unsigned REVERSE_SUB_TAPS = 1,
  localparam int unsigned SUB_LENGTH      = sub_length(NUMBER_TAPS, RATE_CHANGE),
  localparam int unsigned PHASE_W         = index_w(RATE_CHANGE),
  localparam int unsigned SUB_W           = index_w(SUB_LENGTH),
  localparam int unsigned ADDR_W          = index_w(NUMBER_TAPS)
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [SUB_W-1:0]   sub,
  output logic [ADDR_W-1:0]  idx
);

  logic [31:0] row;

  always_comb begin
    row = (REVERSE_SUB_TAPS != 0) ? (SUB_LENGTH - 1 - 32'(sub)) : 32'(sub);
    idx = ADDR_W'(row * RATE_CHANGE + 32'(phase));
  end

endmodule

// File: rtl/polyphase_coeff_loader.sv
// Buffers a prototype filter, then replays it into the interpolating polyphase
// filter in branch order while holding that filter in reset.
module polyphase_coeff_loader
  import polyphase_pkg::*;
#(
  parameter int unsigned NUMBER_TAPS       = DEF_NUMBER_TAPS,
  parameter int unsigned RATE_CHANGE       = DEF_RATE_CHANGE,
  parameter int unsigned COEFFICIENT_WIDTH = DEF_COEFFICIENT_WIDTH,
  parameter int unsigned C_AXI_DATA_WIDTH  = DEF_C_AXI_DATA_WIDTH,
  parameter int unsigned REVERSE_SUB_TAPS  = 1,
  parameter int unsigned RESET_CYCLES      = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  polyphase_coeff_loader_if.slave bus,
  output logic                    filter_aresetn,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error
);

  localparam int unsigned SUB_LENGTH = sub_length(NUMBER_TAPS, RATE_CHANGE);
  localparam int unsigned TAP_CNT_W  = tap_cnt_w(NUMBER_TAPS);
  localparam int unsigned PHASE_W    = index_w(RATE_CHANGE);
  localparam int unsigned SUB_W      = index_w(SUB_LENGTH);
  localparam int unsigned ADDR_W     = index_w(NUMBER_TAPS);
  localparam int unsigned RST_W      = tap_cnt_w(RESET_CYCLES);

  loader_state_e state_q, state_d;

  logic [TAP_CNT_W-1:0]        in_cnt_q, k_q;
  logic [RST_W-1:0]            rst_cnt_q;
  logic [PHASE_W-1:0]          p_q;
  logic [SUB_W-1:0]            j_q;
  logic                        tready_q, frst_q, error_q, wvalid_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_W-1:0]           wr_addr, rd_addr;
  logic                        beat, fill_end, issue, final_hs;
  logic                        store, err_set, err_clr;

  logic signed [COEFFICIENT_WIDTH-1:0] buf_q [NUMBER_TAPS];

  assign beat     = bus.s_coeff_tvalid & tready_q;
  assign fill_end = (in_cnt_q == TAP_CNT_W'(NUMBER_TAPS - 1));
  assign issue    = (state_q == WRITE) && (!wvalid_q || bus.m_coeffs_wready) &&
                    (k_q != TAP_CNT_W'(NUMBER_TAPS));
  // k has already run past the last write, so this handshake closes the load
  assign final_hs = (state_q == WRITE) && wvalid_q && bus.m_coeffs_wready &&
                    (k_q == TAP_CNT_W'(NUMBER_TAPS));
  assign wr_addr  = (state_q == IDLE) ? '0 : in_cnt_q[ADDR_W-1:0];

  polyphase_coeff_order #(
    .NUMBER_TAPS      (NUMBER_TAPS),
    .RATE_CHANGE      (RATE_CHANGE),
    .REVERSE_SUB_TAPS (REVERSE_SUB_TAPS)
  ) u_order (
    .phase (p_q),
    .sub   (j_q),
    .idx   (rd_addr)
  );

  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          store = 1'b1;
          if (bus.s_coeff_tlast) begin
            err_set = 1'b1;
          end else begin
            err_clr = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (beat) begin
          store = 1'b1;
          if (fill_end) begin
            err_set = !bus.s_coeff_tlast;
            state_d = bus.s_coeff_tlast ? RST : FLUSH;
          end else if (bus.s_coeff_tlast) begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH: if (beat && bus.s_coeff_tlast) state_d = IDLE;
      RST:   if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) state_d = WRITE;
      WRITE: if (final_hs) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tready and filter reset are registered from state_d so both are 0 under reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      frst_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= state_d inside {IDLE, FILL, FLUSH};
      frst_q   <= !(state_d inside {RST, WRITE});
      if (err_set)      error_q <= 1'b1;
      else if (err_clr) error_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_cnt_q  <= '0;
      rst_cnt_q <= '0;
      k_q       <= '0;
      p_q       <= '0;
      j_q       <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      if (store) in_cnt_q <= (state_q == IDLE) ? TAP_CNT_W'(1) : in_cnt_q + 1'b1;
      rst_cnt_q <= (state_q == RST) ? rst_cnt_q + 1'b1 : '0;
      if (state_q != WRITE) begin
        k_q <= '0;
        p_q <= '0;
        j_q <= '0;
      end else if (issue) begin
        k_q <= k_q + 1'b1;
        if (p_q == PHASE_W'(RATE_CHANGE - 1)) begin
          p_q <= '0;
          j_q <= (j_q == SUB_W'(SUB_LENGTH - 1)) ? '0 : j_q + 1'b1;
        end else begin
          p_q <= p_q + 1'b1;
        end
      end
      if (issue) begin
        wvalid_q <= 1'b1;
        wdata_q  <= C_AXI_DATA_WIDTH'(buf_q[rd_addr]);
      end else if (bus.m_coeffs_wready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (store) buf_q[wr_addr] <= bus.s_coeff_tdata;
  end

  assign bus.s_coeff_tready  = tready_q;
  assign bus.m_coeffs_wvalid = wvalid_q;
  assign bus.m_coeffs_wdata  = wdata_q;
  assign bus.m_coeffs_wstrb  = wvalid_q ? '1 : '0;
  assign filter_aresetn      = frst_q;
  assign busy                = (state_q != IDLE);
  assign load_done           = (state_q == DONE);
  assign load_error          = error_q;

endmodule

// File: tb/tb_polyphase_coeff_loader.sv
// Directed/random bench: two loaders (reversed and natural sub-tap order) share one stimulus.
module tb_polyphase_coeff_loader;

  localparam int unsigned N  = 32;
  localparam int unsigned R  = 8;
  localparam int unsigned S  = N / R;
  localparam int unsigned RC = 4;

  logic aclk = 1'b0;
  logic aresetn;
  logic tvalid, tlast, wready;
  logic [15:0] tdata;
  logic frst0, busy0, done0, err0;
  logic frst1, busy1, done1, err1;
  bit   rand_ready;

  logic [15:0] h [N];
  logic [31:0] q0[$], q1[$];
  int unsigned n_pass, n_total, done_cnt0, done_cnt1, frst_low0, accepted;
  bit          stall0, stall1;
  logic [31:0] prev0, prev1;

  polyphase_coeff_loader_if #(.COEFFICIENT_WIDTH(16), .C_AXI_DATA_WIDTH(32)) bus0 ();
  polyphase_coeff_loader_if #(.COEFFICIENT_WIDTH(16), .C_AXI_DATA_WIDTH(32)) bus1 ();

  assign bus0.s_coeff_tdata   = tdata;
  assign bus0.s_coeff_tvalid  = tvalid;
  assign bus0.s_coeff_tlast   = tlast;
  assign bus0.m_coeffs_wready = wready;
  assign bus1.s_coeff_tdata   = tdata;
  assign bus1.s_coeff_tvalid  = tvalid;
  assign bus1.s_coeff_tlast   = tlast;
  assign bus1.m_coeffs_wready = wready;

  polyphase_coeff_loader #(
    .NUMBER_TAPS(N), .RATE_CHANGE(R), .COEFFICIENT_WIDTH(16),
    .C_AXI_DATA_WIDTH(32), .REVERSE_SUB_TAPS(1), .RESET_CYCLES(RC)
  ) dut_rev (
    .aclk(aclk), .aresetn(aresetn), .bus(bus0),
    .filter_aresetn(frst0), .busy(busy0), .load_done(done0), .load_error(err0)
  );

  polyphase_coeff_loader #(
    .NUMBER_TAPS(N), .RATE_CHANGE(R), .COEFFICIENT_WIDTH(16),
    .C_AXI_DATA_WIDTH(32), .REVERSE_SUB_TAPS(0), .RESET_CYCLES(RC)
  ) dut_fwd (
    .aclk(aclk), .aresetn(aresetn), .bus(bus1),
    .filter_aresetn(frst1), .busy(busy1), .load_done(done1), .load_error(err1)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write k goes to branch k%R as its (k/R)-th sub-tap; reversed order walks taps backwards.
  function automatic logic [31:0] model_write(input int unsigned k, input bit rev);
    int unsigned phase, row, src;
    phase = k % R;
    row   = k / R;
    src   = rev ? (S - 1 - row) * R + phase : k;
    return {{16{h[src][15]}}, h[src]};
  endfunction

  initial wready = 1'b1;
  always @(posedge aclk) begin
    #1;
    wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall0) begin
        check("stall_wvalid_rev", bus0.m_coeffs_wvalid, 1);
        check("stall_wdata_rev", bus0.m_coeffs_wdata, prev0);
      end
      if (stall1) check("stall_wdata_fwd", bus1.m_coeffs_wdata, prev1);
      check("wstrb_rev", bus0.m_coeffs_wstrb, bus0.m_coeffs_wvalid ? 4'hF : 4'h0);
      if (bus0.m_coeffs_wvalid && wready) q0.push_back(bus0.m_coeffs_wdata);
      if (bus1.m_coeffs_wvalid && wready) q1.push_back(bus1.m_coeffs_wdata);
      stall0 = bus0.m_coeffs_wvalid && !wready;
      stall1 = bus1.m_coeffs_wvalid && !wready;
      prev0  = bus0.m_coeffs_wdata;
      prev1  = bus1.m_coeffs_wdata;
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
      if (!frst0) frst_low0++;
    end else begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic last);
    int unsigned guard;
    guard = 0;
    @(negedge aclk); #2;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    while (!bus0.s_coeff_tready && guard < 200) begin
      @(negedge aclk); #2;
      guard++;
    end
    if (guard >= 200) check("beat_accept_timeout", bus0.s_coeff_tready, 1);
    @(posedge aclk);
    accepted++;
  endtask

  task automatic stop_stream();
    @(negedge aclk); #2;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic run_load(input string tag);
    int unsigned lat, guard;
    q0.delete();
    q1.delete();
    done_cnt0 = 0;
    done_cnt1 = 0;
    for (int i = 0; i < N; i++) begin
      send_beat(h[i], i == N - 1);
      if (i == 0) begin
        #1;
        check({tag, "_err_clear"}, err0, 0);
        check({tag, "_busy_fill"}, busy0, 1);
      end
    end
    stop_stream();
    check({tag, "_tready_rst"}, bus0.s_coeff_tready, 0);
    check({tag, "_frst_rst"}, frst0, 0);
    lat = 0;
    while (!bus0.m_coeffs_wvalid && lat < 100) begin
      @(negedge aclk); #2;
      lat++;
    end
    check({tag, "_first_wvalid_latency"}, lat, RC + 1);
    guard = 0;
    while (!done0 && guard < 5000) begin
      @(negedge aclk); #2;
      guard++;
    end
    check({tag, "_done_rev"}, done0, 1);
    check({tag, "_done_fwd"}, done1, 1);
    check({tag, "_handshakes_at_done"}, q0.size(), N);
    check({tag, "_frst_released"}, frst0, 1);
    @(negedge aclk); #2;
    check({tag, "_done_pulse_width"}, done0, 0);
    check({tag, "_busy_idle"}, busy0, 0);
    check({tag, "_done_count"}, done_cnt0, 1);
    check({tag, "_done_count_fwd"}, done_cnt1, 1);
    check({tag, "_writes_fwd"}, q1.size(), N);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_rev_w%0d", tag, k), (k < q0.size()) ? q0[k] : 'x, model_write(k, 1'b1));
      check($sformatf("%s_fwd_w%0d", tag, k), (k < q1.size()) ? q1[k] : 'x, model_write(k, 1'b0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned guard;
    aresetn = 1'b1;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    rand_ready = 1'b0;
    #1 aresetn = 1'b0;
    #2;
    check("rst_tready", bus0.s_coeff_tready, 0);
    check("rst_wvalid", bus0.m_coeffs_wvalid, 0);
    check("rst_wdata", bus0.m_coeffs_wdata, 0);
    check("rst_wstrb", bus0.m_coeffs_wstrb, 0);
    check("rst_frst", frst0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_error", err0, 0);
    check("rst_frst_fwd", frst1, 0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_frst", frst0, 1);
    check("post_rst_tready", bus0.s_coeff_tready, 1);

    // ascending coefficients, no backpressure
    for (int i = 0; i < N; i++) h[i] = 16'(i + 1);
    run_load("inc");

    // random coefficients with negatives, 50% wready
    for (int i = 0; i < N; i++) h[i] = 16'($urandom);
    h[5]  = 16'hFFFD;
    h[20] = 16'h8000;
    rand_ready = 1'b1;
    run_load("rnd");
    check("sext_fwd_w5", q1[5], 32'hFFFF_FFFD);
    rand_ready = 1'b0;

    // early tlast on beat 10
    frst_low0 = 0;
    q0.delete();
    for (int i = 0; i < 10; i++) send_beat(16'($urandom), i == 9);
    stop_stream();
    check("short_error", err0, 1);
    check("short_busy", busy0, 0);
    check("short_tready", bus0.s_coeff_tready, 1);
    repeat (20) @(negedge aclk);
    #2;
    check("short_writes", q0.size(), 0);
    check("short_frst_untouched", frst_low0, 0);
    check("short_error_sticky", err0, 1);

    for (int i = 0; i < N; i++) h[i] = 16'($urandom);
    rand_ready = 1'b1;
    run_load("after_short");
    rand_ready = 1'b0;

    // overlong frame: 35 beats, tlast only on the last
    frst_low0 = 0;
    accepted  = 0;
    q0.delete();
    for (int i = 0; i < 35; i++) send_beat(16'($urandom), i == 34);
    stop_stream();
    check("long_accepted", accepted, 35);
    repeat (5) @(negedge aclk);
    #2;
    check("long_error", err0, 1);
    check("long_error_fwd", err1, 1);
    check("long_busy", busy0, 0);
    check("long_writes", q0.size(), 0);
    check("long_frst_untouched", frst_low0, 0);

    // reset in the middle of the write phase
    for (int i = 0; i < N; i++) h[i] = 16'($urandom);
    q0.delete();
    done_cnt0 = 0;
    for (int i = 0; i < N; i++) send_beat(h[i], i == N - 1);
    stop_stream();
    guard = 0;
    while (q0.size() < 10 && guard < 200) begin
      @(negedge aclk); #2;
      guard++;
    end
    check("mid_reached_10_writes", q0.size() >= 10, 1);
    aresetn = 1'b0;
    #1;
    check("mid_wvalid", bus0.m_coeffs_wvalid, 0);
    check("mid_wdata", bus0.m_coeffs_wdata, 0);
    check("mid_wstrb", bus0.m_coeffs_wstrb, 0);
    check("mid_tready", bus0.s_coeff_tready, 0);
    check("mid_frst", frst0, 0);
    check("mid_busy", busy0, 0);
    check("mid_done", done0, 0);
    check("mid_error", err0, 0);
    check("mid_no_done", done_cnt0, 0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) h[i] = 16'($urandom);
    run_load("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/polyphase_coeff_loader.md
Name: polyphase_coeff_loader

Overview:
Sequencer that loads a new prototype low-pass filter into the interpolating polyphase filter. It accepts the prototype coefficients h[0..NUMBER_TAPS-1] in natural order on an AXI-Stream slave and buffers the full set. It then holds the polyphase filter in reset and replays the coefficients on the filter's coefficient write channel, in the per-phase order the filter's one-hot write rotation requires. Finally it releases the filter and reports completion. It sits between the control-plane coefficient source and the polyphase filter's coeffs_axi_w* channel.

Parameters:
NUMBER_TAPS, 32, prototype filter length; must be a multiple of RATE_CHANGE.
RATE_CHANGE, 8, number of polyphase branches; must be at least 2.
COEFFICIENT_WIDTH, 16, coefficient bits (signed); must not exceed C_AXI_DATA_WIDTH.
C_AXI_DATA_WIDTH, 32, width of the write data toward the filter.
REVERSE_SUB_TAPS, 1, 1 = each branch receives its sub-taps last-first; 0 = first-first.
RESET_CYCLES, 4, number of cycles filter_aresetn is held low before the first write; must be at least 1.

Ports:
aclk  in  1  single clock for all logic
aresetn  in  1  asynchronous active-low reset
s_coeff_tdata  in  COEFFICIENT_WIDTH  prototype coefficient, natural order
s_coeff_tvalid  in  1  coefficient valid
s_coeff_tready  out  1  loader can accept a coefficient
s_coeff_tlast  in  1  marks h[NUMBER_TAPS-1]
m_coeffs_wvalid  out  1  write valid toward the filter
m_coeffs_wready  in  1  filter write ready
m_coeffs_wdata  out  C_AXI_DATA_WIDTH  sign-extended coefficient
m_coeffs_wstrb  out  C_AXI_DATA_WIDTH/8  all ones whenever wvalid is high, else 0
filter_aresetn  out  1  active-low reset for the polyphase filter and its coefficient logic
busy  out  1  high in every state except IDLE
load_done  out  1  one-cycle pulse when a load completes
load_error  out  1  sticky framing error; cleared when the next accepted load starts

Behaviour:
- Reset (aresetn low, asynchronous):
  - state = IDLE; all counters = 0.
  - s_coeff_tready = 0, m_coeffs_wvalid = 0, m_coeffs_wdata = 0, m_coeffs_wstrb = 0.
  - filter_aresetn = 0, busy = 0, load_done = 0, load_error = 0.
  - On the first clock after reset deassertion, filter_aresetn goes to 1.
- Buffer: NUMBER_TAPS x COEFFICIENT_WIDTH register array. Written at in_cnt; read combinationally. It is not cleared by reset.
- State IDLE:
  - s_coeff_tready = 1.
  - On the first beat accepted (tvalid & tready): store it at index 0, set in_cnt = 1, clear load_error, go to FILL.
  - If that first beat also carries tlast and NUMBER_TAPS > 1: set load_error and stay in IDLE.
- State FILL:
  - s_coeff_tready = 1; each accepted beat is stored at in_cnt, then in_cnt increments.
  - Accepted beat with tlast while in_cnt < NUMBER_TAPS-1: set load_error, go to IDLE. The filter is untouched.
  - Accepted beat with in_cnt == NUMBER_TAPS-1 and tlast: go to RST, rst_cnt = 0.
  - Accepted beat with in_cnt == NUMBER_TAPS-1 and no tlast: set load_error, go to FLUSH.
- State FLUSH:
  - s_coeff_tready = 1; accepted beats are discarded.
  - Accepted beat with tlast: go to IDLE.
- State RST:
  - s_coeff_tready = 0, filter_aresetn = 0.
  - After RESET_CYCLES cycles in RST: go to WRITE with k = 0.
- State WRITE:
  - filter_aresetn = 0 and s_coeff_tready = 0 for the whole state.
  - Output register: m_coeffs_wvalid and m_coeffs_wdata are registered and load when (!m_coeffs_wvalid | m_coeffs_wready).
  - Write k carries h[idx(k)], where p = k mod RATE_CHANGE, j = k / RATE_CHANGE and S = NUMBER_TAPS/RATE_CHANGE:
    - REVERSE_SUB_TAPS = 1: idx = (S-1-j)*RATE_CHANGE + p.
    - REVERSE_SUB_TAPS = 0: idx = k.
  - Track p and j as separate wrap counters; no divider.
  - wvalid, wdata and wstrb hold stable while wvalid & !wready.
  - Throughput: one write per cycle while wready stays high.
  - When the handshake for write NUMBER_TAPS-1 completes: wvalid drops next cycle and the block goes to DONE.
- State DONE (1 cycle): filter_aresetn = 1, load_done = 1, then go to IDLE.
- Width rule: m_coeffs_wdata is the coefficient sign-extended to C_AXI_DATA_WIDTH.
- Reset mid-operation: returns to IDLE with filter_aresetn low. The filter therefore restarts with cleared coefficient pointers; the partial load is lost and no load_done is produced.
- Latency: from the tlast beat to the first wvalid is RESET_CYCLES+1 cycles. A full load under no backpressure takes NUMBER_TAPS + RESET_CYCLES + 3 cycles after tlast.

Decomposition:
- Package polyphase_pkg holds:
  - Derived constants SUB_LENGTH = NUMBER_TAPS/RATE_CHANGE, TAP_CNT_W = $clog2(NUMBER_TAPS+1), PHASE_W = $clog2(RATE_CHANGE).
  - The loader state encoding (IDLE, FILL, FLUSH, RST, WRITE, DONE).
- One natural sub-module: polyphase_coeff_order, a combinational k -> idx mapper driven from the p and j counters. It is reusable by a future decimating loader.

Test Plan:
- NUMBER_TAPS=32, RATE_CHANGE=8, REVERSE=1; h[n]=n+1, tlast on beat 32, wready=1 -> RST lasts 4 cycles with filter_aresetn=0. Writes are 25..32, 17..24, 9..16, 1..8, with wstrb=4'hF. Then a single load_done pulse, and filter_aresetn=1.
- Same stimulus with REVERSE=0 -> writes 1..32 in order. Coefficient -3 (16'hFFFD) produces wdata 32'hFFFFFFFD.
- tlast on beat 10 -> load_error=1, no RST, filter_aresetn stays 1, zero writes. The next clean load clears load_error at its first beat.
- 32 beats with no tlast, then 3 more beats with tlast on the third -> load_error=1, all 35 beats accepted, zero writes, state back to IDLE.
- wready random at 50% -> wdata/wvalid stable while stalled, exactly 32 handshakes in the REVERSE=1 order, and load_done only after the 32nd handshake.
- aresetn pulsed low after 10 writes -> all outputs at reset values immediately. After release, a fresh full load completes with the correct 32-write sequence.
